// File: rtl/regfile_writeback.sv
// Writeback stage driving the 8x16 register file write port.
// Merges never-stalled ALU results with handshaked load results that are
// buffered in a small FIFO. Queued loads whose destination is overwritten by
// a younger ALU result are squashed (kept in the FIFO but marked dead).
// Optional feature macro: WB_BYPASS_EN adds a same-cycle read bypass for the
// two register file read ports.
module regfile_writeback #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [ADDR_W-1:0]             alu_des,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_des,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          reg_write_en,
  output logic [ADDR_W-1:0]             reg_write_des,
  output logic [DATA_W-1:0]             reg_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]             rd_addr_1,
  input  logic [ADDR_W-1:0]             rd_addr_2,
  input  logic [DATA_W-1:0]             rf_data_1,
  input  logic [DATA_W-1:0]             rf_data_2,
  output logic [DATA_W-1:0]             byp_data_1,
  output logic [DATA_W-1:0]             byp_data_2
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FIFO_DEPTH-1:0] live;
  logic [ADDR_W-1:0]     fifo_des  [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  push_live;

  // Full/empty come only from the registered count, so mem_ready never
  // depends on mem_valid. An ALU result always wins the write port.
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty     = (fifo_count == '0);
  assign mem_ready = !full;
  assign push      = mem_valid && !full;
  assign pop       = !alu_valid && !empty;
  // A load pushed alongside an ALU write to the same register is older, so it
  // enters the FIFO already dead.
  assign push_live = !(alu_valid && (mem_des == alu_des));

  // Live bits: cleared on reset, squashed by a matching ALU write, set on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (alu_valid && (fifo_des[i] == alu_des)) live[i] <= 1'b0;
      end
      if (push) live[wr_ptr] <= push_live;
    end
  end

  // FIFO payload storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_des[wr_ptr]  <= mem_des;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Write port register: ALU first, then FIFO head (dead head gives en=0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_des  <= '0;
      reg_write_data <= '0;
    end else if (alu_valid) begin
      reg_write_en   <= 1'b1;
      reg_write_des  <= alu_des;
      reg_write_data <= alu_data;
    end else if (pop) begin
      reg_write_en   <= live[rd_ptr];
      reg_write_des  <= fifo_des[rd_ptr];
      reg_write_data <= fifo_data[rd_ptr];
    end else begin
      reg_write_en   <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the pending write to readers during the cycle before the
  // register file itself reflects it.
  assign byp_data_1 = (reg_write_en && (reg_write_des == rd_addr_1)) ? reg_write_data : rf_data_1;
  assign byp_data_2 = (reg_write_en && (reg_write_des == rd_addr_2)) ? reg_write_data : rf_data_2;
`endif

endmodule
